// File: rtl/spike_router.sv
// Spike fan-out router: edge-captures spikes, expands each through a CSR table, queues packets in a FIFO.
// Optional build macro SPIKE_ROUTER_SELF_FILTER_EN drops entries whose destination equals the source.
module spike_router #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int PTR_W       = 5,
    parameter int MAX_CONN    = 32,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [NUM_NEURONS-1:0]           spikes,
    input  logic [NUM_NEURONS*ADDR_W-1:0]    neuron_addresses_initialization,
    input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
    input  logic [MAX_CONN*ADDR_W-1:0]       downstream_connections_initialization,
    output logic [2*ADDR_W-1:0]              packet,
    output logic                             packet_valid,
    input  logic                             packet_ready,
    output logic                             busy,
    output logic [7:0]                       dropped_count
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int FA_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EMIT} state_t;

    state_t                   r_state, w_state_nxt;
    logic [NUM_NEURONS-1:0]   r_prev, r_pending;
    logic [NUM_NEURONS-1:0]   w_rise, w_drop, w_sel_hot, w_sel_clr;
    logic [IDX_W-1:0]         w_sel_idx, r_idx;
    logic [PTR_W-1:0]         r_cur, r_end, w_ptr_lo, w_ptr_hi;
    logic [7:0]               r_dropped;
    logic [15:0]              w_drop_n, w_drop_sum;
    logic [ADDR_W-1:0]        w_src, w_ds;
    logic                     w_skip, w_full, w_last, w_advance, w_push, w_pop;
    logic [2*ADDR_W-1:0]      r_mem [FIFO_DEPTH];
    logic [FA_W-1:0]          r_wr, r_rd;
    logic [FA_W:0]            r_count;

    // Lowest pending index wins the SELECT slot.
    always_comb begin
        w_sel_idx = '0;
        w_sel_hot = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx    = IDX_W'(i);
                w_sel_hot    = '0;
                w_sel_hot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_lo = connection_pointer_initialization[int'(w_sel_idx)*PTR_W +: PTR_W];
    assign w_ptr_hi = connection_pointer_initialization[(int'(w_sel_idx)+1)*PTR_W +: PTR_W];
    assign w_src    = neuron_addresses_initialization[int'(r_idx)*ADDR_W +: ADDR_W];
    assign w_ds     = downstream_connections_initialization[int'(r_cur)*ADDR_W +: ADDR_W];

`ifdef SPIKE_ROUTER_SELF_FILTER_EN
    assign w_skip = (w_ds == w_src);
`else
    assign w_skip = 1'b0;
`endif

    assign w_full    = (r_count == (FA_W+1)'(FIFO_DEPTH));
    assign w_last    = (({1'b0, r_cur} + (PTR_W+1)'(1)) == {1'b0, r_end});
    // Skipped entries never touch the FIFO, so they advance even when it is full.
    assign w_advance = (r_state == S_EMIT) && (w_skip || !w_full);
    assign w_push    = (r_state == S_EMIT) && !w_skip && !w_full;
    assign w_pop     = packet_valid && packet_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_clr   = '0;
        case (r_state)
            S_IDLE:   if (|r_pending) w_state_nxt = S_SELECT;
            S_SELECT: begin
                w_sel_clr = w_sel_hot;
                if (w_ptr_lo < w_ptr_hi)            w_state_nxt = S_EMIT;
                else if (|(r_pending & ~w_sel_hot)) w_state_nxt = S_SELECT;
                else                                w_state_nxt = S_IDLE;
            end
            S_EMIT:   if (w_advance && w_last) w_state_nxt = (|r_pending) ? S_SELECT : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A fresh edge on a bit being consumed this cycle is a new capture, not a merge.
    assign w_rise = spikes & ~r_prev;
    assign w_drop = w_rise & r_pending & ~w_sel_clr;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_NEURONS; i++) w_drop_n = w_drop_n + 16'(w_drop[i]);
    end
    assign w_drop_sum = 16'(r_dropped) + w_drop_n;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_pending <= '0;
            r_dropped <= '0;
            r_idx     <= '0;
            r_cur     <= '0;
            r_end     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= clear ? '0 : spikes;
            r_pending <= (r_pending & ~w_sel_clr) | w_rise;
            r_dropped <= (w_drop_sum > 16'd255) ? 8'hFF : w_drop_sum[7:0];
            if (r_state == S_SELECT) begin
                r_idx <= w_sel_idx;
                r_cur <= w_ptr_lo;
                r_end <= w_ptr_hi;
            end else if (w_advance) begin
                r_cur <= r_cur + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {w_src, w_ds};
                r_wr        <= r_wr + FA_W'(1);
            end
            if (w_pop) r_rd <= r_rd + FA_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FA_W+1)'(1);
                2'b01:   r_count <= r_count - (FA_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign packet        = r_mem[r_rd];
    assign packet_valid  = (r_count != '0);
    assign busy          = (|r_pending) || (r_state != S_IDLE) || (r_count != '0);
    assign dropped_count = r_dropped;
endmodule
